// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction-fetch
// port (read only) and the data-access port (read/write), with round-robin
// arbitration on simultaneous requests and the memory's read/write handshake.
module mem_port_arbiter #(
  parameter int unsigned WORD_SIZE    = 16,
  parameter int unsigned WRITE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ack,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ack,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  logic [WORD_SIZE-1:0] data,
  input  logic                 inputReady
);

  localparam int unsigned CW = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_REL, WRITE, WR_REL} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  state_t               state;
  port_t                rr;
  port_t                owner;
  logic [CW-1:0]        wcnt;
  logic                 data_oe;
  logic [WORD_SIZE-1:0] data_out;
  logic                 pick_d;

  assign data = data_oe ? data_out : 'z;

  // Grant selection: a lone requester wins; on conflict the rr pointer decides.
  always_comb begin
    pick_d = 1'b0;
    pick_d = d_req & (~i_req | (rr == PORT_D));
  end

  // Access sequencer: grant, memory handshake, ack pulse and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr       <= PORT_D;
      owner    <= PORT_I;
      wcnt     <= '0;
      data_oe  <= 1'b0;
      data_out <= '0;
      readM    <= 1'b0;
      writeM   <= 1'b0;
      address  <= '0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          // Holding off while an ack is visible gives the requester one cycle
          // to drop req, so a finished access is not re-granted by accident.
          if ((i_req || d_req) && !i_ack && !d_ack) begin
            address <= pick_d ? d_addr : i_addr;
            owner   <= pick_d ? PORT_D : PORT_I;
            if (i_req && d_req) rr <= pick_d ? PORT_I : PORT_D;
            if (pick_d && d_we) begin
              writeM   <= 1'b1;
              data_out <= d_wdata;
              data_oe  <= 1'b1;
              wcnt     <= CW'(WRITE_CYCLES - 1);
              state    <= WRITE;
            end else begin
              readM <= 1'b1;
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (inputReady) begin
            if (owner == PORT_D) begin
              d_rdata <= data;
              d_ack   <= 1'b1;
            end else begin
              i_rdata <= data;
              i_ack   <= 1'b1;
            end
            readM <= 1'b0;
            state <= RD_REL;
          end
        end
        RD_REL: begin
          if (!inputReady) state <= IDLE;
        end
        WRITE: begin
          if (wcnt == '0) begin
            writeM <= 1'b0;
            state  <= WR_REL;
          end else begin
            wcnt <= wcnt - CW'(1);
          end
        end
        WR_REL: begin
          d_ack   <= 1'b1;
          data_oe <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter against a behavioural
// memory with programmable read latency and an independent reference array.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic [15:0] i_rdata;
  logic        i_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic        readM;
  logic        writeM;
  logic [15:0] address;
  wire  [15:0] data;
  logic        inputReady = 1'b0;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.WORD_SIZE(16), .WRITE_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .readM(readM), .writeM(writeM), .address(address), .data(data),
    .inputReady(inputReady)
  );

  always #5 clk = ~clk;

  // Power-on contents of the memory model
  function automatic logic [15:0] init_val(input logic [7:0] a);
    if (a == 8'd0) return 16'h9023;
    if (a == 8'd1) return 16'h0001;
    if (a == 8'd2) return 16'hFFFF;
    return {a, ~a};
  endfunction

  // Memory model: read answers after 'lat' extra cycles, write stores while writeM
  logic [15:0] mem [0:255];
  bit          wv  [0:255];
  int          lat = 0;
  int          cnt = 0;
  always @(posedge clk) begin
    if (writeM) begin
      mem[address[7:0]] <= data;
      wv[address[7:0]]  <= 1'b1;
    end
    if (!readM) begin
      inputReady <= 1'b0;
      cnt        <= lat;
    end else if (!inputReady) begin
      if (cnt == 0) inputReady <= 1'b1;
      else          cnt <= cnt - 1;
    end
  end
  assign data = inputReady ? (wv[address[7:0]] ? mem[address[7:0]] : init_val(address[7:0])) : 'z;

  // Protocol monitor
  int  rw_bad = 0, ack_bad = 0, grants = 0, acks = 0;
  logic readM_q = 1'b0, writeM_q = 1'b0;
  always @(negedge clk) begin
    if (readM && writeM) rw_bad++;
    if (i_ack && d_ack) ack_bad++;
    if ((readM && !readM_q) || (writeM && !writeM_q)) grants++;
    if (i_ack || d_ack) acks++;
    readM_q  = readM;
    writeM_q = writeM;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] a, input logic [15:0] exp, input string tag);
    int n = 0;
    i_req  = 1'b1;
    i_addr = a;
    while (!i_ack && n < 60) begin step(); n++; end
    chk({tag, "_ack"}, {31'd0, i_ack}, 32'd1);
    chk({tag, "_rdata"}, {16'd0, i_rdata}, {16'd0, exp});
    i_req = 1'b0;
  endtask

  task automatic dread(input logic [15:0] a, input logic [15:0] exp, input string tag);
    int n = 0;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = a;
    while (!d_ack && n < 60) begin step(); n++; end
    chk({tag, "_ack"}, {31'd0, d_ack}, 32'd1);
    chk({tag, "_rdata"}, {16'd0, d_rdata}, {16'd0, exp});
    d_req = 1'b0;
  endtask

  logic [15:0] refm [0:255];
  bit          ord  [0:3];
  logic [15:0] ordv [0:3];

  initial begin
    int n, wcyc, ackn, g0, a0;
    bit data_ok;

    for (int i = 0; i < 256; i++) refm[i] = init_val(8'(i));

    // ---- reset values
    do_reset();
    chk("rst_readM", {31'd0, readM}, 32'd0);
    chk("rst_writeM", {31'd0, writeM}, 32'd0);
    chk("rst_address", {16'd0, address}, 32'd0);
    chk("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
    chk("rst_rdata", {i_rdata, d_rdata}, 32'd0);

    // ---- 1: fetch of 0x0000
    i_req  = 1'b1;
    i_addr = 16'h0000;
    step();
    chk("t1_readM", {31'd0, readM}, 32'd1);
    chk("t1_address", {16'd0, address}, 32'd0);
    fetch(16'h0000, 16'h9023, "t1");
    step();
    chk("t1_ack_pulse", {31'd0, i_ack}, 32'd0);
    step(); step();

    // ---- 2: write 0x1234 to 0x00F0, then read back
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h00F0; d_wdata = 16'h1234;
    n = 0; wcyc = 0; data_ok = 1'b1;
    while (!d_ack && n < 60) begin
      step(); n++;
      if (writeM) begin
        wcyc++;
        if (data !== 16'h1234) data_ok = 1'b0;
      end
    end
    d_req = 1'b0;
    chk("t2_ack_cycle", n, 32'd4);
    chk("t2_writeM_cycles", wcyc, 32'd2);
    chk("t2_bus_data", {31'd0, data_ok}, 32'd1);
    step(); step();
    dread(16'h00F0, 16'h1234, "t2_rb");
    refm[8'hF0] = 16'h1234;
    step(); step();

    // ---- 3: simultaneous requests, data first, then alternate
    do_reset();
    i_req = 1'b1; i_addr = 16'h0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0001;
    n = 0; ackn = 0;
    while (ackn < 4 && n < 100) begin
      step(); n++;
      if (d_ack) begin ord[ackn] = 1'b1; ordv[ackn] = d_rdata; ackn++; end
      else if (i_ack) begin ord[ackn] = 1'b0; ordv[ackn] = i_rdata; ackn++; end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("t3_ack_count", ackn, 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < ackn) begin
        chk($sformatf("t3_order%0d", k), {31'd0, ord[k]}, (k % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("t3_data%0d", k), {16'd0, ordv[k]}, (k % 2 == 0) ? 32'h0001 : 32'h9023);
      end
    end
    step(); step(); step();

    // ---- 4: reset while waiting on a slow read
    do_reset();
    lat = 20;
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0002;
    step(); step();
    chk("t4_readM_wait", {31'd0, readM}, 32'd1);
    reset = 1'b1;
    d_req = 1'b0;
    step();
    chk("t4_readM_abort", {31'd0, readM}, 32'd0);
    chk("t4_address_abort", {16'd0, address}, 32'd0);
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (d_ack) n++;
    end
    chk("t4_no_ack", n, 32'd0);
    lat = 1;
    dread(16'h0002, 16'hFFFF, "t4_reissue");
    step(); step(); step();

    // ---- 5: random transactions against the reference array
    g0 = grants;
    a0 = acks;
    for (int t = 0; t < 150; t++) begin
      bit ie, de, we, gi, gd;
      logic [15:0] ia, da, wd;
      ie = 1'($urandom_range(0, 1));
      de = 1'($urandom_range(0, 1)) | ~ie;
      we = 1'($urandom_range(0, 1));
      ia = 16'($urandom_range(16, 31));
      da = 16'($urandom_range(0, 15));
      wd = 16'($urandom);
      lat = $urandom_range(0, 3);
      i_req = ie; i_addr = ia;
      d_req = de; d_we = we; d_addr = da; d_wdata = wd;
      gi = ~ie; gd = ~de; n = 0;
      while (!(gi && gd) && n < 80) begin
        step(); n++;
        if (i_ack && !gi) begin
          gi = 1'b1;
          chk("t5_i_rdata", {16'd0, i_rdata}, {16'd0, refm[ia[7:0]]});
          i_req = 1'b0;
        end
        if (d_ack && !gd) begin
          gd = 1'b1;
          if (we) refm[da[7:0]] = wd;
          else chk("t5_d_rdata", {16'd0, d_rdata}, {16'd0, refm[da[7:0]]});
          d_req = 1'b0;
        end
      end
      if (!(gi && gd)) chk("t5_timeout", {30'd0, gi, gd}, 32'd3);
    end
    step(); step(); step(); step();
    chk("t5_grants_eq_acks", grants - g0, acks - a0);
    chk("mon_rw_exclusive", rw_bad, 32'd0);
    chk("mon_single_ack", ack_bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
